mr_debug_uart: RTL and testbench

//   Downstream consumer of the computer's 16-bit register DEBUG word (top-level OUT0).

---
 rtl/mr_debug_uart.sv | 154 +++++++++++++++
 tb/tb_mr_debug_uart.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mr_debug_uart.sv
// mr_debug_uart: sends the 16-bit register DEBUG word as an ASCII hex line
// ("1A2F\r\n") over an 8N1 UART TX pin. Only the latest value is sent, so
// values that change during a frame are coalesced.
//
// Ports
//   CLK    in   1   system clock, all state on the rising edge
//   RST    in   1   asynchronous active-low reset
//   DEBUG  in   16  debug word, sampled synchronously
//   EN     in   1   1: frames may start; 0: no new frame (a running frame completes)
//   SEND   in   1   1-cycle pulse: force a frame even if DEBUG is unchanged
//   TX     out  1   UART serial output, idle high (registered)
//   BUSY   out  1   high while a frame is on the wire (registered)
module mr_debug_uart #(
    parameter int CLK_DIV  = 434,   // clock cycles per UART bit, >= 2
    parameter bit EOL_CRLF = 1'b1   // 1: CR,LF line end; 0: LF only
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DEBUG,
    input  logic        EN,
    input  logic        SEND,
    output logic        TX,
    output logic        BUSY
);

    localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [2:0]     LAST_CHAR = EOL_CRLF ? 3'd5 : 3'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [2:0]    char_idx, char_idx_n;
    logic [15:0]   snap, snap_n;
    logic [15:0]   last_sent, last_sent_n;
    logic          pend_send, pend_send_n;
    logic          tx_n, busy_n;

    logic [7:0]    cur_char;
    logic [2:0]    bit_nxt;
    logic          trigger;
    logic          baud_end;

    // Uppercase hex digit: '0'..'9' = 0x30.., 'A'..'F' = 0x41..
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        cur_char = 8'h0A;
        case (char_idx)
            3'd0: cur_char = hex_char(snap[15:12]);
            3'd1: cur_char = hex_char(snap[11:8]);
            3'd2: cur_char = hex_char(snap[7:4]);
            3'd3: cur_char = hex_char(snap[3:0]);
            3'd4: cur_char = EOL_CRLF ? 8'h0D : 8'h0A;
            default: cur_char = 8'h0A;
        endcase
    end

    assign trigger  = EN & ((DEBUG != last_sent) | SEND | pend_send);
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign bit_nxt  = bit_idx + 3'd1;

    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        char_idx_n  = char_idx;
        snap_n      = snap;
        last_sent_n = last_sent;
        pend_send_n = pend_send;
        tx_n        = TX;
        busy_n      = BUSY;

        if (state == IDLE) begin
            if (trigger) begin
                snap_n      = DEBUG;
                last_sent_n = DEBUG;
                pend_send_n = 1'b0;
                char_idx_n  = 3'd0;
                baud_cnt_n  = '0;
                state_n     = START;
                tx_n        = 1'b0;
                busy_n      = 1'b1;
            end else if (SEND) begin
                // SEND with EN low is remembered until EN returns
                pend_send_n = 1'b1;
            end
        end else begin
            // A SEND that arrives mid-frame forces one more frame afterwards
            if (SEND) pend_send_n = 1'b1;
            baud_cnt_n = baud_cnt + BW'(1);
            if (baud_end) begin
                baud_cnt_n = '0;
                case (state)
                    START: begin
                        state_n   = DATA;
                        bit_idx_n = 3'd0;
                        tx_n      = cur_char[0];
                    end
                    DATA: begin
                        if (bit_idx == 3'd7) begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end else begin
                            bit_idx_n = bit_nxt;
                            tx_n      = cur_char[bit_nxt];
                        end
                    end
                    STOP: begin
                        if (char_idx == LAST_CHAR) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            // back-to-back characters, no idle gap
                            char_idx_n = char_idx + 3'd1;
                            state_n    = START;
                            tx_n       = 1'b0;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            char_idx  <= 3'd0;
            snap      <= 16'h0000;
            last_sent <= 16'h0000;
            pend_send <= 1'b0;
            TX        <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            bit_idx   <= bit_idx_n;
            char_idx  <= char_idx_n;
            snap      <= snap_n;
            last_sent <= last_sent_n;
            pend_send <= pend_send_n;
            TX        <= tx_n;
            BUSY      <= busy_n;
        end
    end

endmodule

// File: tb/tb_mr_debug_uart.sv
// Bench for mr_debug_uart: two instances (CR,LF and LF-only line endings) at
// 4 cycles per bit. A frame-level model predicts TX/BUSY every cycle; a UART
// decoder turns TX back into bytes for literal per-scenario expectations.
module tb_mr_debug_uart;

    localparam int CD = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] dbg0, dbg1;
    logic        en0, en1, send0, send1;
    logic        tx0, tx1, busy0, busy1;

    always #5 CLK = ~CLK;

    mr_debug_uart #(.CLK_DIV(CD), .EOL_CRLF(1'b1)) u0 (
        .CLK(CLK), .RST(RST), .DEBUG(dbg0), .EN(en0), .SEND(send0), .TX(tx0), .BUSY(busy0));
    mr_debug_uart #(.CLK_DIV(CD), .EOL_CRLF(1'b0)) u1 (
        .CLK(CLK), .RST(RST), .DEBUG(dbg1), .EN(en1), .SEND(send1), .TX(tx1), .BUSY(busy1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit          m_busy [2];
    int          m_cnt  [2];
    logic [15:0] m_last [2];
    bit          m_pend [2];
    logic        m_bits [2][60];

    function automatic logic [7:0] hexm(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    function automatic int flen(input int ch);
        return (ch == 0) ? 60 * CD : 50 * CD;
    endfunction

    task automatic build(input int ch, input logic [15:0] v);
        logic [7:0] c [6];
        int nch;
        c[0] = hexm(int'(v[15:12]));
        c[1] = hexm(int'(v[11:8]));
        c[2] = hexm(int'(v[7:4]));
        c[3] = hexm(int'(v[3:0]));
        if (ch == 0) begin c[4] = 8'h0D; c[5] = 8'h0A; nch = 6; end
        else begin c[4] = 8'h0A; c[5] = 8'h0A; nch = 5; end
        for (int i = 0; i < nch; i++) begin
            m_bits[ch][10*i] = 1'b0;
            for (int b = 0; b < 8; b++) m_bits[ch][10*i+1+b] = c[i][b];
            m_bits[ch][10*i+9] = 1'b1;
        end
    endtask

    task automatic step(input int ch, input logic [15:0] d, input logic en, input logic snd);
        if (!m_busy[ch]) begin
            if (en && (d != m_last[ch] || snd || m_pend[ch])) begin
                build(ch, d);
                m_last[ch] = d;
                m_pend[ch] = 1'b0;
                m_busy[ch] = 1'b1;
                m_cnt[ch]  = 0;
            end else if (snd) m_pend[ch] = 1'b1;
        end else begin
            if (snd) m_pend[ch] = 1'b1;
            m_cnt[ch]++;
            if (m_cnt[ch] == flen(ch)) m_busy[ch] = 1'b0;
        end
    endtask

    // ---------------- UART decoder / busy length ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         rx_act [2];
    int         rx_cnt [2];
    logic [7:0] rx_sh  [2];
    int         blen [2];
    int         last_len [2];
    bit         pbusy [2];

    task automatic monitor(input int ch, input logic tx, input logic bsy);
        if (!rx_act[ch]) begin
            if (tx == 1'b0) begin rx_act[ch] = 1'b1; rx_cnt[ch] = 0; end
        end else begin
            rx_cnt[ch]++;
            if (rx_cnt[ch] >= CD + CD/2 && rx_cnt[ch] < 9*CD && (rx_cnt[ch] - CD/2) % CD == 0)
                rx_sh[ch][(rx_cnt[ch] - CD/2)/CD - 1] = tx;
            if (rx_cnt[ch] == 9*CD + CD/2) begin
                chk($sformatf("stop_bit_ch%0d", ch), 32'(tx), 32'd1);
                if (ch == 0) q0.push_back(rx_sh[ch]); else q1.push_back(rx_sh[ch]);
                rx_act[ch] = 1'b0;
            end
        end
        if (bsy) blen[ch]++;
        else if (pbusy[ch]) begin last_len[ch] = blen[ch]; blen[ch] = 0; end
        pbusy[ch] = bsy;
    endtask

    // Model update on every edge, then per-cycle comparison and decode.
    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                for (int ch = 0; ch < 2; ch++) begin
                    m_busy[ch] = 1'b0; m_cnt[ch] = 0; m_last[ch] = 16'h0; m_pend[ch] = 1'b0;
                    rx_act[ch] = 1'b0; blen[ch] = 0; pbusy[ch] = 1'b0;
                end
            end else begin
                step(0, dbg0, en0, send0);
                step(1, dbg1, en1, send1);
            end
            #1;
            chk("tx0", 32'(tx0), m_busy[0] ? 32'(m_bits[0][m_cnt[0]/CD]) : 32'd1);
            chk("busy0", 32'(busy0), 32'(m_busy[0]));
            chk("tx1", 32'(tx1), m_busy[1] ? 32'(m_bits[1][m_cnt[1]/CD]) : 32'd1);
            chk("busy1", 32'(busy1), 32'(m_busy[1]));
            if (RST) begin
                monitor(0, tx0, busy0);
                monitor(1, tx1, busy1);
            end
        end
    end

    // ---------------- helpers for literal expectations ----------------
    function automatic int qsize(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qpop(input int ch);
        return (ch == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    // Checks the first n decoded bytes (exp packed MSB-first) and consumes them.
    task automatic chk_bytes(input string nm, input int ch, input int n, input logic [47:0] exp);
        chk({nm, "_avail"}, 32'(qsize(ch) >= n), 32'd1);
        if (qsize(ch) >= n)
            for (int i = 0; i < n; i++)
                chk($sformatf("%s_byte%0d", nm, i), 32'(qpop(ch)), 32'(exp[8*(n-1-i) +: 8]));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b0; dbg0 = 16'h0; dbg1 = 16'h0;
        en0 = 1'b1; en1 = 1'b0; send0 = 1'b0; send1 = 1'b0;
        cyc(3);
        chk("reset_tx0", 32'(tx0), 32'd1);
        chk("reset_busy0", 32'(busy0), 32'd0);
        RST = 1'b1;

        // 1: unchanged 0x0000 is not sent; SEND forces "0000\r\n"
        cyc(300);
        chk("t1_idle_bytes", 32'(q0.size()), 32'd0);
        chk("t1_idle_tx", 32'(tx0), 32'd1);
        send0 = 1'b1; cyc(1); send0 = 1'b0;
        cyc(260);
        chk_bytes("t1", 0, 6, 48'h3030_3030_0D0A);
        chk("t1_busy_len", 32'(last_len[0]), 32'd240);

        // 2: change to 0x1A2F, start bit one edge later
        chk("t2_pre_tx", 32'(tx0), 32'd1);
        dbg0 = 16'h1A2F;
        @(posedge CLK); #1;
        chk("t2_tx_fall", 32'(tx0), 32'd0);
        cyc(260);
        chk_bytes("t2", 0, 6, 48'h3141_3246_0D0A);
        chk("t2_no_more", 32'(q0.size()), 32'd0);

        // 3: 0x0002 dropped, only latest 0x0003 follows
        dbg0 = 16'h0001; cyc(50);
        dbg0 = 16'h0002; cyc(50);
        dbg0 = 16'h0003; cyc(600);
        chk_bytes("t3a", 0, 6, 48'h3030_3031_0D0A);
        chk_bytes("t3b", 0, 6, 48'h3030_3033_0D0A);
        chk("t3_no_more", 32'(q0.size()), 32'd0);

        // 4: async reset in the data bits of char 2
        dbg0 = 16'h0004;
        cyc(95);
        chk("t4_busy_before", 32'(busy0), 32'd1);
        RST = 1'b0; dbg0 = 16'h0003;
        #1;
        chk("t4_rst_tx", 32'(tx0), 32'd1);
        chk("t4_rst_busy", 32'(busy0), 32'd0);
        cyc(2);
        q0.delete();
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("t4_restart", 32'(tx0), 32'd0);
        cyc(260);
        chk_bytes("t4", 0, 6, 48'h3030_3033_0D0A);
        chk("t4_no_more", 32'(q0.size()), 32'd0);

        // 5: EN low blocks change and SEND; EN high sends one "BEEF\r\n"
        en0 = 1'b0; dbg0 = 16'h0010; cyc(20);
        dbg0 = 16'hBEEF; cyc(5);
        send0 = 1'b1; cyc(1); send0 = 1'b0;
        cyc(300);
        chk("t5_blocked_bytes", 32'(q0.size()), 32'd0);
        chk("t5_blocked_busy", 32'(busy0), 32'd0);
        en0 = 1'b1;
        cyc(300);
        chk_bytes("t5", 0, 6, 48'h4245_4546_0D0A);
        chk("t5_no_more", 32'(q0.size()), 32'd0);

        // 6: LF-only instance
        dbg1 = 16'hF00D; en1 = 1'b1;
        cyc(250);
        chk_bytes("t6", 1, 5, 48'h0046_3030_440A);
        chk("t6_busy_len", 32'(last_len[1]), 32'd200);
        chk("t6_no_more", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
